// File: rtl/tim_apb_master.sv
// Command-driven APB master feeding timer_top: one request in flight, SETUP/ACCESS sequencing,
// optional pready timeout, and a held response until the consumer accepts it.
module tim_apb_master #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_strb,
   input  logic                req_dbg,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                tim_psel,
   output logic                tim_penable,
   output logic                tim_pwrite,
   output logic [ADDR_W-1:0]   tim_paddr,
   output logic [DATA_W-1:0]   tim_pwdata,
   output logic [DATA_W/8-1:0] tim_pstrb,
   output logic                dbg_mode,
   input  logic                tim_pready,
   input  logic [DATA_W-1:0]   tim_prdata,
   input  logic                tim_pslverr
);

   localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CntW-1:0] CntLim = CntW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_inc;
   logic            timeout_hit;

   assign cnt_inc = cnt_q + CntW'(1);
   // Completion takes priority: the abort only fires on an edge where pready is low.
   assign timeout_hit = (TIMEOUT_CYC != 0) && !tim_pready && (cnt_inc == CntLim);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         tim_psel    <= 1'b0;
         tim_penable <= 1'b0;
         tim_pwrite  <= 1'b0;
         tim_paddr   <= '0;
         tim_pwdata  <= '0;
         tim_pstrb   <= '0;
         dbg_mode    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid && req_ready) begin
                  state_q     <= StSetup;
                  req_ready   <= 1'b0;
                  tim_psel    <= 1'b1;
                  tim_penable <= 1'b0;
                  tim_pwrite  <= req_write;
                  tim_paddr   <= req_addr;
                  tim_pwdata  <= req_write ? req_wdata : '0;
                  tim_pstrb   <= req_write ? req_strb : '0;
                  dbg_mode    <= req_dbg;
               end
            end
            StSetup: begin
               state_q     <= StAccess;
               tim_penable <= 1'b1;
               cnt_q       <= '0;
            end
            StAccess: begin
               if (tim_pready || timeout_hit) begin
                  state_q     <= StResp;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= (tim_pready && !tim_pwrite) ? tim_prdata : '0;
                  rsp_err     <= tim_pready ? tim_pslverr : 1'b1;
                  rsp_timeout <= !tim_pready;
                  tim_psel    <= 1'b0;
                  tim_penable <= 1'b0;
                  tim_pwrite  <= 1'b0;
                  tim_paddr   <= '0;
                  tim_pwdata  <= '0;
                  tim_pstrb   <= '0;
               end
               if (TIMEOUT_CYC != 0) begin
                  cnt_q <= cnt_inc;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  state_q   <= StIdle;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_tim_apb_master.sv
// Randomised bench for tim_apb_master against a stub APB register slave and a
// transaction-level reference model of the register contents and response rules.
module tb_tim_apb_master;

   localparam int unsigned ADDR_W      = 12;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned TIMEOUT_CYC = 16;
   localparam logic [31:0] TcrRst      = 32'h0000_0004;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        req_valid, req_ready, req_write, req_dbg;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        tim_psel, tim_penable, tim_pwrite, dbg_mode;
   logic [11:0] tim_paddr;
   logic [31:0] tim_pwdata;
   logic [3:0]  tim_pstrb;
   logic        tim_pready, tim_pslverr;
   logic [31:0] tim_prdata;

   always #5 sys_clk = ~sys_clk;

   tim_apb_master #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_strb   (req_strb),
      .req_dbg    (req_dbg),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .tim_psel   (tim_psel),
      .tim_penable(tim_penable),
      .tim_pwrite (tim_pwrite),
      .tim_paddr  (tim_paddr),
      .tim_pwdata (tim_pwdata),
      .tim_pstrb  (tim_pstrb),
      .dbg_mode   (dbg_mode),
      .tim_pready (tim_pready),
      .tim_prdata (tim_prdata),
      .tim_pslverr(tim_pslverr)
   );

   logic [87:0] outs;
   assign outs = {req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, tim_psel, tim_penable,
                  tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb, dbg_mode};

   // Stub slave: 16 word registers, wait states before pready, writes of TCR with any bit
   // above [7:0] set are rejected; junk on prdata/pslverr outside ACCESS.
   int unsigned stub_waits;
   bit          stub_hang;
   int unsigned stub_wcnt;
   logic [31:0] stub_mem [16];
   bit   [15:0] stub_valid;
   logic [3:0]  stub_idx;
   logic [31:0] stub_cur;
   logic        stub_acc;

   assign stub_idx    = tim_paddr[5:2];
   assign stub_acc    = tim_psel && tim_penable;
   assign stub_cur    = stub_valid[stub_idx] ? stub_mem[stub_idx] :
                        ((stub_idx == 4'd0) ? TcrRst : 32'h0);
   assign tim_pready  = stub_acc && !stub_hang && (stub_wcnt >= stub_waits);
   assign tim_prdata  = stub_acc ? stub_cur : 32'hDEAD_BEEF;
   assign tim_pslverr = stub_acc ? (tim_pwrite && stub_idx == 4'd0 && |tim_pwdata[31:8]) : 1'b1;

   always @(posedge sys_clk) begin
      if (stub_acc && !tim_pready) stub_wcnt <= stub_wcnt + 1;
      else stub_wcnt <= 0;
      if (stub_acc && tim_pready && tim_pwrite && !tim_pslverr) begin
         for (int b = 0; b < 4; b++)
            stub_mem[stub_idx][8*b +: 8] <= tim_pstrb[b] ? tim_pwdata[8*b +: 8] : stub_cur[8*b +: 8];
         stub_valid[stub_idx] <= 1'b1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] ref_mem [16];
   logic        e_wr, e_dbg, e_err, e_to;
   logic [11:0] e_addr;
   logic [31:0] e_wd, e_rd;
   logic [3:0]  e_st;
   int          e_lat;

   // Reference: decide the outcome of a request from the register model and the slave's timing.
   task automatic txn_setup(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                            input logic [3:0] st, input bit dbg, input int waits, input bit hang);
      int idx;
      idx = int'(addr[5:2]);
      e_wr = wr; e_addr = addr; e_wd = wd; e_st = st; e_dbg = dbg;
      e_to = hang || (waits >= int'(TIMEOUT_CYC));
      if (e_to) begin
         e_rd = 32'h0; e_err = 1'b1; e_lat = int'(TIMEOUT_CYC) + 2;
      end else if (wr) begin
         e_rd = 32'h0; e_err = (idx == 0) && (wd[31:8] != 24'h0); e_lat = 3 + waits;
         if (!e_err)
            for (int b = 0; b < 4; b++) if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
         e_rd = ref_mem[idx]; e_err = 1'b0; e_lat = 3 + waits;
      end
      stub_waits = waits; stub_hang = hang;
      req_write = wr; req_addr = addr; req_wdata = wd; req_strb = st; req_dbg = dbg;
   endtask

   task automatic txn_issue(input string tag);
      int n;
      n = 0;
      @(negedge sys_clk);
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin @(negedge sys_clk); n++; end
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL %s accept: req_ready %b, want 1", tag, req_ready);
      end
      @(posedge sys_clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic txn_track(input string tag);
      int lat, psel_n, pen_n, bad;
      logic [31:0] x_wd;
      logic [3:0]  x_st;
      x_wd = e_wr ? e_wd : 32'h0;
      x_st = e_wr ? e_st : 4'h0;
      lat = 1; psel_n = 0; pen_n = 0; bad = 0;
      @(negedge sys_clk);
      while (!rsp_valid && lat < 100) begin
         if (tim_psel) psel_n++;
         if (tim_penable) pen_n++;
         if ({tim_psel, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb, dbg_mode, req_ready} !==
             {1'b1, e_wr, e_addr, x_wd, x_st, e_dbg, 1'b0} || tim_penable !== (lat > 1)) bad++;
         @(negedge sys_clk);
         lat++;
      end
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL %s apb_stable: %0d bad cycles, want 0", tag, bad); end
      n_cmp++;
      if (lat != e_lat) begin n_err++; $display("FAIL %s latency: %0d, want %0d", tag, lat, e_lat); end
      n_cmp++;
      if (psel_n != e_lat - 1 || pen_n != e_lat - 2) begin
         n_err++;
         $display("FAIL %s psel/penable cycles: %0d/%0d, want %0d/%0d", tag, psel_n, pen_n,
                  e_lat - 1, e_lat - 2);
      end
      n_cmp++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e_rd, e_err, e_to}) begin
         n_err++;
         $display("FAIL %s response: rdata %h err %b to %b, want %h %b %b", tag, rsp_rdata, rsp_err,
                  rsp_timeout, e_rd, e_err, e_to);
      end
      n_cmp++;
      if ({tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb, req_ready} !== 52'h0)
      begin
         n_err++;
         $display("FAIL %s apb_idle: psel %b pen %b addr %h wdata %h strb %h rdy %b, want all 0", tag,
                  tim_psel, tim_penable, tim_paddr, tim_pwdata, tim_pstrb, req_ready);
      end
   endtask

   task automatic txn_consume(input int rdly, input string tag);
      int bad;
      bad = 0;
      repeat (rdly) begin
         if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, req_ready, tim_psel} !==
             {1'b1, e_rd, e_err, e_to, 1'b0, 1'b0}) bad++;
         @(negedge sys_clk);
      end
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL %s rsp_hold: %0d bad cycles, want 0", tag, bad); end
      rsp_ready = 1'b1;
      @(posedge sys_clk);
      #1 rsp_ready = 1'b0;
      @(negedge sys_clk);
      n_cmp++;
      if ({rsp_valid, req_ready, dbg_mode} !== {1'b0, 1'b1, e_dbg}) begin
         n_err++;
         $display("FAIL %s rsp_done: valid %b ready %b dbg %b, want 0 1 %b", tag, rsp_valid,
                  req_ready, dbg_mode, e_dbg);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge sys_clk);
      n_cmp++;
      if (outs !== {1'b1, 87'h0}) begin n_err++; $display("FAIL reset_state: %h, want %h", outs, {1'b1, 87'h0}); end
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      n_cmp++;
      if (outs !== {1'b1, 87'h0}) begin n_err++; $display("FAIL reset_idle: %h, want %h", outs, {1'b1, 87'h0}); end
   endtask

   task automatic test_read_after_reset;
      txn_setup(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 0, 1'b0);
      txn_issue("rd_tcr"); txn_track("rd_tcr"); txn_consume(0, "rd_tcr");
   endtask

   task automatic test_write_tcmp0;
      txn_setup(1'b1, 12'h00C, 32'h0000_00FF, 4'hF, 1'b0, 1, 1'b0);
      txn_issue("wr_tcmp0"); txn_track("wr_tcmp0"); txn_consume(1, "wr_tcmp0");
      txn_setup(1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, 1, 1'b0);
      txn_issue("rd_tcmp0"); txn_track("rd_tcmp0"); txn_consume(0, "rd_tcmp0");
   endtask

   task automatic test_slverr;
      txn_setup(1'b1, 12'h000, 32'hFFFF_0000, 4'hF, 1'b0, 0, 1'b0);
      txn_issue("slverr"); txn_track("slverr"); txn_consume(2, "slverr");
      txn_setup(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 2, 1'b0);
      txn_issue("slverr_rb"); txn_track("slverr_rb"); txn_consume(0, "slverr_rb");
   endtask

   task automatic test_timeout;
      txn_setup(1'b1, 12'h020, 32'h1234_5678, 4'hF, 1'b0, 0, 1'b1);
      txn_issue("to_hang"); txn_track("to_hang"); txn_consume(1, "to_hang");
      txn_setup(1'b1, 12'h024, 32'hCAFE_F00D, 4'hF, 1'b1, 15, 1'b0);
      txn_issue("to_edge_ok"); txn_track("to_edge_ok"); txn_consume(0, "to_edge_ok");
      txn_setup(1'b0, 12'h024, 32'h0, 4'h0, 1'b0, 16, 1'b0);
      txn_issue("to_slow"); txn_track("to_slow"); txn_consume(0, "to_slow");
      txn_setup(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 0, 1'b0);
      txn_issue("to_rb"); txn_track("to_rb"); txn_consume(0, "to_rb");
   endtask

   task automatic test_back_to_back;
      logic [31:0] r_rd;
      logic        r_err, r_to;
      int          bad;
      txn_setup(1'b1, 12'h010, 32'hA5A5_0001, 4'hF, 1'b0, 0, 1'b0);
      txn_issue("b2b_1"); txn_track("b2b_1");
      r_rd = e_rd; r_err = e_err; r_to = e_to;
      txn_setup(1'b0, 12'h010, 32'h0, 4'h0, 1'b1, 1, 1'b0);
      req_valid = 1'b1;
      bad = 0;
      repeat (5) begin
         if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, req_ready, tim_psel, dbg_mode} !==
             {1'b1, r_rd, r_err, r_to, 1'b0, 1'b0, 1'b0}) bad++;
         @(negedge sys_clk);
      end
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL b2b backpressure: %0d bad cycles, want 0", bad); end
      rsp_ready = 1'b1;
      @(posedge sys_clk);
      #1 rsp_ready = 1'b0;
      @(negedge sys_clk);
      n_cmp++;
      if ({rsp_valid, req_ready, tim_psel, dbg_mode} !== 4'b0100) begin
         n_err++;
         $display("FAIL b2b gap: valid %b ready %b psel %b dbg %b, want 0 1 0 0", rsp_valid,
                  req_ready, tim_psel, dbg_mode);
      end
      @(posedge sys_clk);
      #1 req_valid = 1'b0;
      txn_track("b2b_2"); txn_consume(0, "b2b_2");
   endtask

   task automatic test_reset_mid_access;
      txn_setup(1'b0, 12'h008, 32'h0, 4'h0, 1'b1, 0, 1'b1);
      txn_issue("rst_mid");
      repeat (3) @(negedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      n_cmp++;
      if (outs !== {1'b1, 87'h0}) begin n_err++; $display("FAIL rst_mid outputs: %h, want %h", outs, {1'b1, 87'h0}); end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      txn_setup(1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, 1, 1'b0);
      txn_issue("rst_after"); txn_track("rst_after"); txn_consume(0, "rst_after");
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         txn_setup(1'($urandom), 12'($urandom), $urandom, 4'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'b0);
         txn_issue("rand"); txn_track("rand"); txn_consume(int'($urandom_range(0, 3)), "rand");
      end
   endtask

   initial begin
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
      req_dbg = 1'b0; rsp_ready = 1'b0; stub_waits = 0; stub_hang = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
      ref_mem[0] = TcrRst;
      test_reset();
      test_read_after_reset();
      test_write_tcmp0();
      test_slverr();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
